// File: rtl/dcm_sup_pkg.sv
// Shared types and helpers for the DCM lock supervisor.
//   dcm_state_e : per-channel supervisor state
//   bits_for(n) : bits needed to hold values 0..n (never less than 1)
//   max3(a,b,c) : largest of three integers
package dcm_sup_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } dcm_state_e;

  function automatic int bits_for(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dcm_lock_chan.sv
// One supervised DCM channel: input synchronisers, sequencing FSM,
// shared reset/timeout/qualification counter and consecutive-failure count.
//   clkin_i / rstn_i       : supervisor clock, async active-low reset
//   dcm_locked_i           : raw DCM LOCKED (async)
//   dcm_clkin_stopped_i    : raw DCM input-clock-stopped status (async)
//   fault_clr_i            : one-cycle pulse, leaves FAULT
//   dcm_rst_o              : active-high DCM reset
//   ready_o / ready_nxt_o  : qualified lock, and its next-state value
//   fault_o                : retry limit exhausted
//   retries_o              : consecutive failed attempts
//
// state     | meaning
// ST_RST    | DCM held in reset for RST_CYCLES cycles
// ST_WAIT   | reset released, waiting for LOCKED within LOCK_TIMEOUT
// ST_STABLE | lock seen, must hold for STABLE_CYCLES cycles
// ST_RUN    | qualified; any loss restarts the sequence
// ST_FAULT  | too many consecutive failures, DCM held in reset
module dcm_lock_chan
  import dcm_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  localparam int RW = bits_for(MAX_RETRIES)
) (
  input  logic          clkin_i,
  input  logic          rstn_i,
  input  logic          dcm_locked_i,
  input  logic          dcm_clkin_stopped_i,
  input  logic          fault_clr_i,
  output logic          dcm_rst_o,
  output logic          ready_o,
  output logic          ready_nxt_o,
  output logic          fault_o,
  output logic [RW-1:0] retries_o
);

  localparam int CW = bits_for(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RET_LIMIT   = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RET_SAT     = {RW{1'b1}};

  logic [1:0]    lk_sync_q, st_sync_q;
  dcm_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dcm_rst_q, dcm_rst_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic [RW-1:0] retries_q, retries_d;

  logic          lk, st, lost, fail;
  logic [RW-1:0] retries_inc;

  assign lk   = lk_sync_q[1];
  assign st   = st_sync_q[1];
  // Stopped input clock counts as a loss even if LOCKED is still high.
  assign lost = st | ~lk;
  assign retries_inc = (retries_q == RET_SAT) ? retries_q : retries_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dcm_rst_d = dcm_rst_q;
    ready_d   = ready_q;
    fault_d   = fault_q;
    retries_d = retries_q;
    fail      = 1'b0;

    case (state_q)
      ST_RST: begin
        dcm_rst_d = 1'b1;
        if (cnt_q == RST_LAST) begin
          state_d   = ST_WAIT;
          cnt_d     = '0;
          dcm_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (lk && !st) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STABLE: begin
        if (lost) begin
          fail = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          ready_d   = 1'b1;
          retries_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Losing lock after qualification is a re-acquire, not a failure.
        if (lost) begin
          state_d   = ST_RST;
          cnt_d     = '0;
          ready_d   = 1'b0;
          dcm_rst_d = 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clr_i) begin
          state_d   = ST_RST;
          cnt_d     = '0;
          retries_d = '0;
          fault_d   = 1'b0;
          dcm_rst_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_RST;
        cnt_d     = '0;
        dcm_rst_d = 1'b1;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
      end
    endcase

    if (fail) begin
      retries_d = retries_inc;
      cnt_d     = '0;
      dcm_rst_d = 1'b1;
      ready_d   = 1'b0;
      if ((MAX_RETRIES != 0) && (retries_inc == RET_LIMIT)) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else begin
        state_d = ST_RST;
      end
    end
  end

  always_ff @(posedge clkin_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lk_sync_q <= '0;
      st_sync_q <= '0;
      state_q   <= ST_RST;
      cnt_q     <= '0;
      dcm_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      retries_q <= '0;
    end else begin
      lk_sync_q <= {lk_sync_q[0], dcm_locked_i};
      st_sync_q <= {st_sync_q[0], dcm_clkin_stopped_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dcm_rst_q <= dcm_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      retries_q <= retries_d;
    end
  end

  assign dcm_rst_o   = dcm_rst_q;
  assign ready_o     = ready_q;
  assign ready_nxt_o = ready_d;
  assign fault_o     = fault_q;
  assign retries_o   = retries_q;

endmodule

// File: rtl/dcm_lock_supervisor.sv
// Lock supervisor for NCH independent DCM channels.
//   clkin / rstn       : free-running supervisor clock, async active-low reset
//   dcm_locked         : raw LOCKED per channel (async)
//   dcm_clkin_stopped  : raw input-clock-stopped status per channel (async)
//   fault_clr          : one-cycle pulse, clears every faulted channel
//   dcm_rst            : active-high DCM reset per channel
//   ready / all_ready  : per-channel qualified lock, and AND of all channels
//   fault              : per-channel retry limit exhausted
//   retries            : per-channel failure count, channel i at [i*RW +: RW]
module dcm_lock_supervisor
  import dcm_sup_pkg::*;
#(
  parameter int NCH           = 1,
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  localparam int RW = bits_for(MAX_RETRIES)
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic [NCH-1:0]    dcm_locked,
  input  logic [NCH-1:0]    dcm_clkin_stopped,
  input  logic              fault_clr,
  output logic [NCH-1:0]    dcm_rst,
  output logic [NCH-1:0]    ready,
  output logic              all_ready,
  output logic [NCH-1:0]    fault,
  output logic [NCH*RW-1:0] retries
);

  logic [NCH-1:0] ready_nxt;
  logic           all_ready_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    dcm_lock_chan #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRIES  (MAX_RETRIES)
    ) u_chan (
      .clkin_i            (clkin),
      .rstn_i             (rstn),
      .dcm_locked_i       (dcm_locked[i]),
      .dcm_clkin_stopped_i(dcm_clkin_stopped[i]),
      .fault_clr_i        (fault_clr),
      .dcm_rst_o          (dcm_rst[i]),
      .ready_o            (ready[i]),
      .ready_nxt_o        (ready_nxt[i]),
      .fault_o            (fault[i]),
      .retries_o          (retries[i*RW +: RW])
    );
  end

  // Registered from next-state ready so it moves on the same edge as ready.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      all_ready_q <= 1'b0;
    end else begin
      all_ready_q <= &ready_nxt;
    end
  end

  assign all_ready = all_ready_q;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
module tb_dcm_lock_supervisor;

  localparam int NCH = 2;
  localparam int RW  = 2;

  logic              clkin = 1'b0;
  logic              rstn;
  logic [NCH-1:0]    dcm_locked;
  logic [NCH-1:0]    dcm_clkin_stopped;
  logic              fault_clr;
  logic [NCH-1:0]    dcm_rst;
  logic [NCH-1:0]    ready;
  logic              all_ready;
  logic [NCH-1:0]    fault;
  logic [NCH*RW-1:0] retries;

  int total = 0;
  int bad   = 0;
  int edge_n;

  dcm_lock_supervisor #(
    .NCH(2), .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .clkin(clkin), .rstn(rstn), .dcm_locked(dcm_locked),
    .dcm_clkin_stopped(dcm_clkin_stopped), .fault_clr(fault_clr),
    .dcm_rst(dcm_rst), .ready(ready), .all_ready(all_ready),
    .fault(fault), .retries(retries)
  );

  always #5 clkin = ~clkin;

  // Edge 1 is the first rising edge with rstn high.
  always @(posedge clkin or negedge rstn) begin
    if (!rstn) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  // Returns at the falling edge following rising edge n.
  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (edge_n < n && guard < 2000) begin
      @(negedge clkin);
      guard++;
    end
    total++;
    if (edge_n != n) begin
      bad++;
      $display("FAIL wait_edge: reached edge %0d, wanted %0d", edge_n, n);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; dcm_locked = '0; dcm_clkin_stopped = '0; fault_clr = 1'b0;
    repeat (3) @(negedge clkin);
    total++; if (dcm_rst !== 2'b11) begin bad++; $display("FAIL rst_dcm_rst: got %b want 11", dcm_rst); end
    total++; if (ready !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", ready); end
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL rst_fault: got %b want 00", fault); end
    total++; if (retries !== 4'b0000) begin bad++; $display("FAIL rst_retries: got %b want 0000", retries); end
    total++; if (all_ready !== 1'b0) begin bad++; $display("FAIL rst_all_ready: got %b want 0", all_ready); end
    rstn = 1'b1;
    wait_edge(3);
    total++; if (dcm_rst !== 2'b11) begin bad++; $display("FAIL rel_e3_dcm_rst: got %b want 11", dcm_rst); end
    wait_edge(4);
    total++; if (dcm_rst !== 2'b00) begin bad++; $display("FAIL rel_e4_dcm_rst: got %b want 00", dcm_rst); end
  endtask

  // ch0 lock sampled at edge 5: STABLE at 7, ready at 15.
  task automatic test_acquire();
    dcm_locked[0] = 1'b1;
    wait_edge(14);
    total++; if (ready !== 2'b00) begin bad++; $display("FAIL acq_e14_ready: got %b want 00", ready); end
    wait_edge(15);
    total++; if (ready !== 2'b01) begin bad++; $display("FAIL acq_e15_ready: got %b want 01", ready); end
    total++; if (all_ready !== 1'b0) begin bad++; $display("FAIL acq_all_ready: got %b want 0", all_ready); end
    total++; if (retries[1:0] !== 2'd0) begin bad++; $display("FAIL acq_retries0: got %0d want 0", retries[1:0]); end
  endtask

  // ch1 WAIT at 4: timeout at 24, WAIT again at 28, second timeout at 48 -> FAULT.
  task automatic test_never_lock();
    wait_edge(23);
    total++; if (retries[3:2] !== 2'd0 || dcm_rst[1] !== 1'b0) begin bad++; $display("FAIL nl_e23: got retries=%0d rst=%b want 0/0", retries[3:2], dcm_rst[1]); end
    wait_edge(24);
    total++; if (retries[3:2] !== 2'd1 || dcm_rst[1] !== 1'b1 || fault[1] !== 1'b0) begin bad++; $display("FAIL nl_e24: got retries=%0d rst=%b fault=%b want 1/1/0", retries[3:2], dcm_rst[1], fault[1]); end
    wait_edge(27);
    total++; if (dcm_rst[1] !== 1'b1) begin bad++; $display("FAIL nl_e27_rst: got %b want 1", dcm_rst[1]); end
    wait_edge(28);
    total++; if (dcm_rst[1] !== 1'b0) begin bad++; $display("FAIL nl_e28_rst: got %b want 0", dcm_rst[1]); end
    wait_edge(47);
    total++; if (fault[1] !== 1'b0) begin bad++; $display("FAIL nl_e47_fault: got %b want 0", fault[1]); end
    wait_edge(48);
    total++; if (fault[1] !== 1'b1 || retries[3:2] !== 2'd2 || dcm_rst[1] !== 1'b1) begin bad++; $display("FAIL nl_e48: got fault=%b retries=%0d rst=%b want 1/2/1", fault[1], retries[3:2], dcm_rst[1]); end
    wait_edge(52);
    total++; if (fault[1] !== 1'b1 || dcm_rst[1] !== 1'b1) begin bad++; $display("FAIL nl_e52_hold: got fault=%b rst=%b want 1/1", fault[1], dcm_rst[1]); end
  endtask

  // fault_clr sampled at 53: RST entered at 53, WAIT at 57.
  task automatic test_fault_clr();
    fault_clr = 1'b1;
    wait_edge(53);
    fault_clr = 1'b0;
    total++; if (fault[1] !== 1'b0 || retries[3:2] !== 2'd0 || dcm_rst[1] !== 1'b1) begin bad++; $display("FAIL fc_e53: got fault=%b retries=%0d rst=%b want 0/0/1", fault[1], retries[3:2], dcm_rst[1]); end
    total++; if (ready[0] !== 1'b1 || dcm_rst[0] !== 1'b0) begin bad++; $display("FAIL fc_ch0_ignored: got ready=%b rst=%b want 1/0", ready[0], dcm_rst[0]); end
    wait_edge(56);
    total++; if (dcm_rst[1] !== 1'b1) begin bad++; $display("FAIL fc_e56_rst: got %b want 1", dcm_rst[1]); end
    wait_edge(57);
    total++; if (dcm_rst[1] !== 1'b0) begin bad++; $display("FAIL fc_e57_rst: got %b want 0", dcm_rst[1]); end
  endtask

  // ch1 lock sampled at 58: ready[1] and all_ready at 68.
  task automatic test_all_ready();
    dcm_locked[1] = 1'b1;
    wait_edge(67);
    total++; if (all_ready !== 1'b0 || ready !== 2'b01) begin bad++; $display("FAIL ar_e67: got all=%b ready=%b want 0/01", all_ready, ready); end
    wait_edge(68);
    total++; if (all_ready !== 1'b1 || ready !== 2'b11) begin bad++; $display("FAIL ar_e68: got all=%b ready=%b want 1/11", all_ready, ready); end
    total++; if (retries !== 4'b0000) begin bad++; $display("FAIL ar_retries: got %b want 0000", retries); end
  endtask

  // ch0 stopped sampled high at 71..73: ready falls at 73, WAIT at 77,
  // STABLE at 78, ready again at 86.
  task automatic test_clkin_stopped();
    wait_edge(70);
    dcm_clkin_stopped[0] = 1'b1;
    wait_edge(72);
    total++; if (ready[0] !== 1'b1) begin bad++; $display("FAIL cs_e72_ready: got %b want 1", ready[0]); end
    wait_edge(73);
    dcm_clkin_stopped[0] = 1'b0;
    total++; if (ready[0] !== 1'b0 || dcm_rst[0] !== 1'b1 || all_ready !== 1'b0) begin bad++; $display("FAIL cs_e73: got ready=%b rst=%b all=%b want 0/1/0", ready[0], dcm_rst[0], all_ready); end
    total++; if (retries[1:0] !== 2'd0) begin bad++; $display("FAIL cs_retries: got %0d want 0", retries[1:0]); end
    wait_edge(77);
    total++; if (dcm_rst[0] !== 1'b0) begin bad++; $display("FAIL cs_e77_rst: got %b want 0", dcm_rst[0]); end
    wait_edge(85);
    total++; if (ready[0] !== 1'b0) begin bad++; $display("FAIL cs_e85_ready: got %b want 0", ready[0]); end
    wait_edge(86);
    total++; if (ready !== 2'b11 || all_ready !== 1'b1 || retries[1:0] !== 2'd0) begin bad++; $display("FAIL cs_e86: got ready=%b all=%b retries=%0d want 11/1/0", ready, all_ready, retries[1:0]); end
  endtask

  // Lock drop at 89 -> RST at 91, WAIT at 95. Relock sampled 95..99 -> STABLE
  // at 97, drop sampled at 100 -> failure at 102, reset pulse until 106.
  task automatic test_stable_glitch();
    wait_edge(88);
    dcm_locked[0] = 1'b0;
    wait_edge(91);
    total++; if (ready[0] !== 1'b0 || dcm_rst[0] !== 1'b1 || retries[1:0] !== 2'd0) begin bad++; $display("FAIL gl_e91: got ready=%b rst=%b retries=%0d want 0/1/0", ready[0], dcm_rst[0], retries[1:0]); end
    wait_edge(94);
    dcm_locked[0] = 1'b1;
    wait_edge(99);
    dcm_locked[0] = 1'b0;
    wait_edge(101);
    total++; if (retries[1:0] !== 2'd0 || dcm_rst[0] !== 1'b0 || ready[0] !== 1'b0) begin bad++; $display("FAIL gl_e101: got retries=%0d rst=%b ready=%b want 0/0/0", retries[1:0], dcm_rst[0], ready[0]); end
    wait_edge(102);
    total++; if (retries[1:0] !== 2'd1 || dcm_rst[0] !== 1'b1 || fault[0] !== 1'b0) begin bad++; $display("FAIL gl_e102: got retries=%0d rst=%b fault=%b want 1/1/0", retries[1:0], dcm_rst[0], fault[0]); end
    wait_edge(105);
    total++; if (dcm_rst[0] !== 1'b1 || ready[0] !== 1'b0) begin bad++; $display("FAIL gl_e105: got rst=%b ready=%b want 1/0", dcm_rst[0], ready[0]); end
    wait_edge(106);
    total++; if (dcm_rst[0] !== 1'b0 || ready[0] !== 1'b0 || ready[1] !== 1'b1) begin bad++; $display("FAIL gl_e106: got rst=%b ready=%b want 0/10", dcm_rst[0], ready); end
  endtask

  // Relock sampled at 107 -> STABLE at 109; pull rstn between clock edges.
  task automatic test_async_reset();
    dcm_locked[0] = 1'b1;
    wait_edge(111);
    total++; if (ready !== 2'b10 || retries[1:0] !== 2'd1) begin bad++; $display("FAIL ar_pre: got ready=%b retries=%0d want 10/1", ready, retries[1:0]); end
    #2 rstn = 1'b0;
    #1;
    total++; if (dcm_rst !== 2'b11) begin bad++; $display("FAIL async_dcm_rst: got %b want 11", dcm_rst); end
    total++; if (ready !== 2'b00 || all_ready !== 1'b0) begin bad++; $display("FAIL async_ready: got %b/%b want 00/0", ready, all_ready); end
    total++; if (fault !== 2'b00 || retries !== 4'b0000) begin bad++; $display("FAIL async_fault_retries: got %b/%b want 00/0000", fault, retries); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_never_lock();
    test_fault_clr();
    test_all_ready();
    test_clkin_stopped();
    test_stable_glitch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
